// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter between the
// fetch port and the data port.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_e;

    localparam int MAXDSTREAK_DEFAULT = 4;
    localparam int STREAKW            = 4;

endpackage

// File: rtl/perf_counter.sv
// Free-running profiling counter: counts enabled cycles, wraps modulo 2^W,
// synchronous active-high reset.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the fetch
// port and the load/store port, with per-port stalls and wait counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAXDSTREAK = MAXDSTREAK_DEFAULT,
    parameter int CNTW       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IReq,
    input  logic [31:0]     IAdr,
    output logic [31:0]     IRData,
    output logic            IStall,
    input  logic            DReq,
    input  logic            DWe,
    input  logic [31:0]     DAdr,
    input  logic [31:0]     DWData,
    output logic [31:0]     DRData,
    output logic            DStall,
    output logic            MemReq,
    output logic            MemWe,
    output logic [31:0]     MemAdr,
    output logic [31:0]     MemWData,
    input  logic [31:0]     MemRData,
    input  logic            MemAck,
    output logic [CNTW-1:0] IWaitCnt,
    output logic [CNTW-1:0] DWaitCnt,
    output arb_state_e      DbgState
);

    localparam logic [STREAKW-1:0] STREAK_MAX = STREAKW'(MAXDSTREAK);

    arb_state_e         state_q, state_d;
    logic [31:0]        adr_q, adr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        irdata_q, irdata_d;
    logic [31:0]        drdata_q, drdata_d;
    logic [STREAKW-1:0] streak_q, streak_d;

    logic ack_i;
    logic ack_d;
    logic can_grant;
    logic i_wins;

    assign ack_i     = (state_q == IBUSY) && MemAck;
    assign ack_d     = (state_q == DBUSY) && MemAck;
    assign can_grant = (state_q == IDLE) || ack_i || ack_d;

    // Data normally wins; a fetch that has watched MAXDSTREAK data grants goes next.
    assign i_wins = IReq && (!DReq || (streak_q >= STREAK_MAX));

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        streak_d = streak_q;

        if (ack_i) begin
            irdata_d = MemRData;
        end
        if (ack_d) begin
            drdata_d = MemRData;
        end

        if (can_grant) begin
            if (i_wins) begin
                state_d = IBUSY;
                adr_d   = IAdr;
                we_d    = 1'b0;
                wdata_d = '0;
            end else if (DReq) begin
                state_d = DBUSY;
                adr_d   = DAdr;
                we_d    = DWe;
                wdata_d = DWData;
            end else begin
                state_d = IDLE;
            end
        end

        if (!IReq) begin
            streak_d = '0;
        end else if (can_grant && i_wins) begin
            streak_d = '0;
        end else if (can_grant && DReq && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + {{(STREAKW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            streak_q <= streak_d;
        end
    end

    assign MemReq   = (state_q != IDLE);
    assign MemWe    = (state_q == DBUSY) && we_q;
    assign MemAdr   = adr_q;
    assign MemWData = wdata_q;

    // Completion data is forwarded in the ack cycle so the stage can advance immediately.
    assign IRData = ack_i ? MemRData : irdata_q;
    assign DRData = ack_d ? MemRData : drdata_q;
    assign IStall = IReq && !ack_i;
    assign DStall = DReq && !ack_d;

    assign DbgState = state_q;

    perf_counter #(.W(CNTW)) u_iwait (
        .clk     (clk),
        .reset   (reset),
        .en_i    (IStall),
        .count_o (IWaitCnt)
    );

    perf_counter #(.W(CNTW)) u_dwait (
        .clk     (clk),
        .reset   (reset),
        .en_i    (DStall),
        .count_o (DWaitCnt)
    );

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the instruction fetch port (F stage, read-only) and the data port (M stage, LDR/STR) of the pipelined ARM core.
- Produces per-port stall outputs that the hazard unit ORs into StallF and StallM.
- Keeps wait-cycle counters for the profiling testbench.
- Sits in top, between the arm core and the memory model.

Parameters:
- MAXDSTREAK, 4: maximum consecutive data grants while an instruction request is pending. Range 1..15.
- CNTW, 32: width of the profiling counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- IReq  in  1  instruction fetch request
- IAdr  in  32  fetch address
- IRData  out  32  fetched instruction
- IStall  out  1  fetch not yet complete
- DReq  in  1  data access request
- DWe  in  1  1 = store, 0 = load
- DAdr  in  32  data address
- DWData  in  32  store data
- DRData  out  32  load data
- DStall  out  1  data access not yet complete
- MemReq  out  1  memory transaction valid
- MemWe  out  1  memory write enable
- MemAdr  out  32  memory address
- MemWData  out  32  memory write data
- MemRData  in  32  memory read data
- MemAck  in  1  transaction complete; MemRData valid this cycle
- IWaitCnt  out  CNTW  cycles with IStall high
- DWaitCnt  out  CNTW  cycles with DStall high

Behaviour:
- FSM states:
  - IDLE: no transaction outstanding.
  - IBUSY: instruction transaction outstanding.
  - DBUSY: data transaction outstanding.
- Grant (in IDLE, or in the MemAck cycle of the current transaction):
  - Data wins, unless IReq has been pending through MAXDSTREAK consecutive data grants; then instruction wins.
  - Grant latches the address/We/WData of the winning port into registers.
  - Next state is IBUSY or DBUSY.
  - With no request, return to IDLE.
- Memory side:
  - MemReq=1 in IBUSY/DBUSY only.
  - MemAdr/MemWe/MemWData come from the latched registers and stay stable until MemAck.
  - MemWe=0 in IBUSY.
- Completion: in the MemAck cycle, the grantee's Stall is 0 (combinational from MemAck & state) and its RData = MemRData. In all other cycles RData holds the last completed value (registered).
- Stall rule: IStall = IReq & ~(IBUSY & MemAck); DStall likewise for DReq/DBUSY. A requester granted but not yet acked stays stalled.
- Latency: request in IDLE at cycle 0 → MemReq from cycle 1 → earliest completion is cycle 1 when the memory acks in the same cycle. Back-to-back grants add no idle cycle.
- Requester contract:
  - Req/Adr/We/WData are held stable while that port's Stall=1.
  - A Req seen in the cycle after its completion is a new request.
  - A request deasserted before grant is dropped.
  - A request deasserted while its transaction is outstanding: the transaction still completes and its result is discarded.
- Streak counter (4 bits):
  - Increments on each data grant while IReq=1.
  - Clears on instruction grant or when IReq=0.
  - Saturates at MAXDSTREAK.
- Profiling counters:
  - IWaitCnt increments every cycle IStall=1; DWaitCnt every cycle DStall=1.
  - Both wrap modulo 2^CNTW.
- Simultaneous IReq and DReq in IDLE: data is granted, and IStall=1 for at least the data latency plus the instruction latency.
- MemAck in IDLE: ignored; no state change and no counter effect.
- Reset (synchronous, overrides all; also mid-transaction): state IDLE, MemReq=0, MemWe=0, MemAdr/MemWData=0, IRData=DRData=0, streak=0, IWaitCnt=DWaitCnt=0. Stall outputs follow their equations, with state IDLE. An outstanding memory transaction is abandoned; a MemAck arriving after reset is ignored.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the typedef enum logic [1:0] for states {IDLE, IBUSY, DBUSY};
  - the constant for the default MAXDSTREAK.
- One sub-module, perf_counter (CNTW-bit, enable, sync reset, wrap), instantiated twice for IWaitCnt and DWaitCnt.

Test Plan:
- IReq only, IAdr=0x100, memory acks 3 cycles after MemReq rises → IStall high 3 cycles, then low with IRData=MemRData=0xE3A00001 in the ack cycle; IWaitCnt=3.
- IReq and DReq together in IDLE, DWe=1, DAdr=0x64, DWData=7 → MemAdr=0x64, MemWe=1 first. Fetch is issued in the data-ack cycle and its MemReq stays continuous with no idle cycle.
- MAXDSTREAK=4 with DReq renewed each completion and IReq held → 4 data transactions, then an instruction grant, then data again.
- Load DAdr=0x80 acked with 0x12345678 → DRData=0x12345678 in the ack cycle, and holds it afterwards while DReq=0.
- Reset asserted in DBUSY before MemAck → next cycle state IDLE, MemReq=0, counters 0; a later MemAck causes no Stall change.
- MemAck pulsed in IDLE → outputs, state and counters unchanged.
